regfile_wb_queue: RTL
=====================

// Module: regfile_wb_queue
// PURPOSE
//  Writeback queue that drives the register file's single write port (wrt_en/dest/data, sampled on negedge clk).
//  Accepts writeback requests from the execute/memory stages via valid/ready and buffers them in an in-order FIFO.
//  Drains one entry per cycle into the register file unless the port is held.
//  Provides pending/forwarding lookups so decode can read values that are queued but not yet written.
// PARAMETERS
//  DATA_WIDTH     32  bits per register / writeback data
//  ADDRESS_WIDTH  5   register address width
//  DEPTH          4   queue entries (power of two, >=2)
// PORTS
//  clk           in   1              clock; all state updates on posedge
//  rst           in   1              asynchronous, active-low reset (0 = reset)
//  wb_valid      in   1              writeback request present
//  wb_ready      out  1              queue can accept (= !full)
//  wb_dest       in   ADDRESS_WIDTH  destination register
//  wb_data       in   DATA_WIDTH     data to write
//  port_hold     in   1              1 = do not issue a write this cycle
//  rg_wrt_en     out  1              to register file write enable
//  rg_wrt_dest   out  ADDRESS_WIDTH  to register file write address
//  rg_wrt_data   out  DATA_WIDTH     to register file write data
//  lk_addr1      in   ADDRESS_WIDTH  lookup address 1 (decode rs1)
//  lk_addr2      in   ADDRESS_WIDTH  lookup address 2 (decode rs2)
//  lk_hit1       out  1              a queued entry targets lk_addr1
//  lk_data1      out  DATA_WIDTH     data of youngest such entry, else 0
//  lk_hit2       out  1              as lk_hit1 for lk_addr2
//  lk_data2      out  DATA_WIDTH     as lk_data1 for lk_addr2
//  q_count       out  $clog2(DEPTH)+1 current occupancy
// BEHAVIOUR
//  - State: circular FIFO, head ptr, tail ptr, count (0..DEPTH). rst=0 clears ptrs/count immediately (async); entry
//    contents need not reset. During reset: wb_ready=0, rg_wrt_en=0, lk_hit*=0, q_count=0, all data outputs 0.
//  - Push: wb_valid && wb_ready at posedge -> entry stored at tail, tail++ (wraps DEPTH-1 -> 0).
//  - x0: push with wb_dest==0 completes the handshake but stores nothing (count unchanged).
//  - Issue (combinational from head): rg_wrt_en = (count!=0) && !port_hold; dest/data = head entry, 0 when empty.
//  - Pop: at posedge when rg_wrt_en==1 -> head++, count--. Register file writes at the preceding negedge, so an
//    entry pushed at posedge N into an empty queue is written at the negedge in cycle N and popped at posedge N+1.
//  - No same-cycle bypass: a request is never issued in the cycle it is presented.
//  - wb_ready = (count != DEPTH), derived from registered count only; push+pop in same cycle when full is NOT
//    allowed (ready is 0). Push+pop when 0<count<DEPTH: count unchanged, both ptrs advance.
//  - Order: entries written strictly in push order; WAW on same dest resolves to the younger value.
//  - Lookup (combinational): scan valid entries; hit if dest matches; data from youngest match. lk_addr==0 -> hit=0,
//    data=0. The entry being issued this cycle still counts as a hit (not yet visible in the register file).
//  - port_hold=1 freezes head; pushes continue until full.
//  - rst asserted mid-operation discards all queued entries; no write is issued after reset asserts.
// TESTING
//  1 Reset: rst=0 with 3 queued -> q_count=0, rg_wrt_en=0, wb_ready=0; release -> wb_ready=1.
//  2 Single push dest=5 data=0xDEADBEEF at N -> rg_wrt_en=1 dest=5 data=0xDEADBEEF in cycle N only; q_count 1->0.
//  3 port_hold=1, push 4 entries (dest 1..4) -> wb_ready=0, q_count=4; 5th push stalls; drop hold -> writes 1,2,3,4 in
//    consecutive cycles, ready returns after first pop.
//  4 Push dest=7 0x11 then dest=7 0x22 with hold=1 -> lk_addr1=7 gives hit=1 data=0x22; lk_addr2=8 hit=0.
//  5 Push dest=0 data=0xFFFF -> handshake completes, q_count stays 0, rg_wrt_en never asserts, lk_addr1=0 hit=0.
//  6 Continuous push+pop for 2*DEPTH+1 cycles -> pointers wrap, every data written exactly once, in order.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order writeback queue feeding the register file write port
module regfile_wb_queue #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int DEPTH         = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wb_valid,
   output logic                     o_wb_ready,
   input  logic [ADDRESS_WIDTH-1:0] i_wb_dest,
   input  logic [DATA_WIDTH-1:0]    i_wb_data,
   input  logic                     i_port_hold,
   output logic                     o_rg_wrt_en,
   output logic [ADDRESS_WIDTH-1:0] o_rg_wrt_dest,
   output logic [DATA_WIDTH-1:0]    o_rg_wrt_data,
   input  logic [ADDRESS_WIDTH-1:0] i_lk_addr1,
   input  logic [ADDRESS_WIDTH-1:0] i_lk_addr2,
   output logic                     o_lk_hit1,
   output logic [DATA_WIDTH-1:0]    o_lk_data1,
   output logic                     o_lk_hit2,
   output logic [DATA_WIDTH-1:0]    o_lk_data2,
   output logic [$clog2(DEPTH):0]   o_q_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDRESS_WIDTH-1:0] r_dest [DEPTH];
   logic [DATA_WIDTH-1:0]    r_data [DEPTH];
   logic [PTR_W-1:0]         r_head;
   logic [PTR_W-1:0]         r_tail;
   logic [CNT_W-1:0]         r_count;

   logic                     w_empty;
   logic                     w_store;
   logic                     w_pop;
   logic [PTR_W-1:0]         w_idx;

   // Ready comes only from the registered count, so a full queue never pushes and pops together.
   assign o_wb_ready = i_rst && (r_count != CNT_W'(DEPTH));
   assign w_empty    = (r_count == '0);
   // Writes to x0 finish the handshake but are dropped instead of occupying a slot.
   assign w_store    = i_wb_valid && o_wb_ready && (i_wb_dest != '0);
   assign w_pop      = o_rg_wrt_en;

   assign o_rg_wrt_en   = !w_empty && !i_port_hold;
   assign o_rg_wrt_dest = w_empty ? '0 : r_dest[r_head];
   assign o_rg_wrt_data = w_empty ? '0 : r_data[r_head];
   assign o_q_count     = r_count;

   // Scan entries oldest to youngest so the last match (youngest) supplies the forwarded data.
   always_comb begin
      o_lk_hit1  = 1'b0;
      o_lk_data1 = '0;
      o_lk_hit2  = 1'b0;
      o_lk_data2 = '0;
      w_idx      = r_head;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PTR_W'(k);
         if (CNT_W'(k) < r_count) begin
            if ((i_lk_addr1 != '0) && (r_dest[w_idx] == i_lk_addr1)) begin
               o_lk_hit1  = 1'b1;
               o_lk_data1 = r_data[w_idx];
            end
            if ((i_lk_addr2 != '0) && (r_dest[w_idx] == i_lk_addr2)) begin
               o_lk_hit2  = 1'b1;
               o_lk_data2 = r_data[w_idx];
            end
         end
      end
   end

   // Entry storage needs no reset; validity is tracked by head/count alone.
   always_ff @(posedge i_clk) begin
      if (w_store) begin
         r_dest[r_tail] <= i_wb_dest;
         r_data[r_tail] <= i_wb_data;
      end
   end

   // Pointer and occupancy bookkeeping; reset discards every queued entry at once.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_store) r_tail <= r_tail + 1'b1;
         if (w_pop)   r_head <= r_head + 1'b1;
         r_count <= r_count + {{PTR_W{1'b0}}, w_store} - {{PTR_W{1'b0}}, w_pop};
      end
   end

endmodule
